// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the five-source round-robin scheduler.
// Holds the source count, select width, state encoding and the round-robin search.
package mux_sched_pkg;

   localparam int NUM_SRC = 5;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Scans req upward from ptr, wrapping 4->0; returns {found, idx} of the first set bit.
   function automatic logic [SEL_W:0] rr_search(input logic [NUM_SRC-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
      logic             found;
      logic [SEL_W-1:0] idx;
      int unsigned      c;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 0; k < NUM_SRC; k++) begin
         c = (int'(ptr) + k) % NUM_SRC;
         if (!found && req[c]) begin
            found = 1'b1;
            idx   = 3'(c);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [NUM_SRC-1:0] onehot5(input logic [SEL_W-1:0] idx);
      return 5'b00001 << idx;
   endfunction

endpackage

// File: rtl/mux5_1.sv
// Five-input operand multiplexer with true and complemented outputs.
// Select codes above 4 are never driven by the scheduler; they produce zero.
module mux5_1 #(
   parameter int SZE = 4
) (
   input  logic [2:0]     sel,
   input  logic [SZE-1:0] in0,
   input  logic [SZE-1:0] in1,
   input  logic [SZE-1:0] in2,
   input  logic [SZE-1:0] in3,
   input  logic [SZE-1:0] in4,
   output logic [SZE-1:0] out,
   output logic [SZE-1:0] outbar
);

   // Operand selection.
   always_comb begin
      out = '0;
      case (sel)
         3'd0:    out = in0;
         3'd1:    out = in1;
         3'd2:    out = in2;
         3'd3:    out = in3;
         3'd4:    out = in4;
         default: out = '0;
      endcase
   end

   assign outbar = ~out;

endmodule

// File: rtl/rr_mux5_sched.sv
// Round-robin scheduler granting one of five sources a bounded burst on mux5_1.
// gnt/sel are registered; valid/last are combinational from req and registered state.
import mux_sched_pkg::*;

module rr_mux5_sched #(
   parameter int SZE       = 4,
   parameter int MAX_BEATS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [SZE-1:0] in0,
   input  logic [SZE-1:0] in1,
   input  logic [SZE-1:0] in2,
   input  logic [SZE-1:0] in3,
   input  logic [SZE-1:0] in4,
   input  logic [4:0]     req,
   output logic [4:0]     gnt,
   output logic [2:0]     sel,
   output logic [SZE-1:0] out,
   output logic           valid,
   input  logic           ready,
   output logic           last
);

   localparam int            BW        = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

   state_e        state_q, state_d;
   logic [2:0]    owner_q, owner_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [2:0]    sel_q, sel_d;
   logic [4:0]    gnt_q, gnt_d;

   logic          owner_req_s;
   logic          xfer_s;
   logic          release_s;
   logic [2:0]    next_ptr_s;
   logic [2:0]    search_ptr_s;
   logic          found_s;
   logic [2:0]    win_s;

   assign owner_req_s  = req[owner_q];
   assign valid        = (state_q == GRANT) & owner_req_s;
   assign last         = valid & (beats_q == LAST_BEAT);
   assign xfer_s       = valid & ready;
   assign release_s    = (state_q == GRANT) & ((xfer_s & last) | ~owner_req_s);
   assign next_ptr_s   = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
   // On release the search already uses the advanced pointer, enabling back-to-back grants.
   assign search_ptr_s = release_s ? next_ptr_s : ptr_q;
   assign {found_s, win_s} = rr_search(req, search_ptr_s);

   // Next-state, grant and burst-counter logic.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      beats_d = beats_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d = GRANT;
               owner_d = win_s;
               sel_d   = win_s;
               gnt_d   = onehot5(win_s);
               beats_d = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = 5'b00000;
            end
         end
         GRANT: begin
            if (release_s) begin
               ptr_d = next_ptr_s;
               if (found_s) begin
                  state_d = GRANT;
                  owner_d = win_s;
                  sel_d   = win_s;
                  gnt_d   = onehot5(win_s);
                  beats_d = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 5'b00000;
               end
            end else if (xfer_s) begin
               beats_d = beats_q + BW'(1);
            end else begin
               beats_d = beats_q;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 5'b00000;
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 3'd0;
         ptr_q   <= 3'd0;
         beats_q <= '0;
         sel_q   <= 3'd0;
         gnt_q   <= 5'b00000;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         beats_q <= beats_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt = gnt_q;
   assign sel = sel_q;

   mux5_1 #(.SZE(SZE)) u_mux (
      .sel    (sel_q),
      .in0    (in0),
      .in1    (in1),
      .in2    (in2),
      .in3    (in3),
      .in4    (in4),
      .out    (out),
      .outbar ()
   );

endmodule

// File: doc/rr_mux5_sched.md
# rr_mux5_sched

Round-robin scheduler that shares the five-input `mux5_1` datapath between five requesters. Each requester presents a `SZE`-bit operand and a request line. The block grants one source at a time for a bounded burst and drives the mux select. The selected operand is forwarded downstream under a valid/ready handshake. It sits directly in front of `mux5_1` and owns the only driver of its `sel` input.

## Interface
Parameters:
- `SZE`, 4, data width of each source and of `out`.
- `MAX_BEATS`, 4, maximum transfers per grant; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in0`..`in4`  in  SZE each  source operands.
- `req`  in  5  per-source request; bit i belongs to `in<i>`.
- `gnt`  out  5  one-hot grant; all zero when idle.
- `sel`  out  3  registered select to `mux5_1`; values 0..4 only.
- `out`  out  SZE  selected operand (the `mux5_1` `out`).
- `valid`  out  1  `out` holds a beat for downstream.
- `ready`  in  1  downstream accepts the beat.
- `last`  out  1  current beat is the final beat of this grant.

## Operation
- States: IDLE, GRANT. Registers: `state`, `owner` (3b), `ptr` (3b, next search start), `beats` (counter of width $clog2(MAX_BEATS+1)).
- Arbitration search: scan `req` from index `ptr` upward, wrapping 4→0. The first set bit wins.
- IDLE behaviour:
  - `gnt=0`, `valid=0`, `last=0`, `sel` holds its last value.
  - At a clock edge with any `req` bit set: `owner` = winner, `sel` = winner, `gnt` = onehot(winner), `beats` = 0, and the block enters GRANT.
- GRANT outputs:
  - `valid = req[owner]` (combinational).
  - `last = valid & (beats == MAX_BEATS-1)`.
  - `out` passes through `mux5_1` from the registered `sel`.
- Transfer: one beat completes at any edge with `valid & ready`. `beats` then increments.
- Release condition, evaluated at each edge while in GRANT, with (a) or (b) true:
  - (a) a transfer completes with `last=1`;
  - (b) `req[owner]` is sampled low.
- On release:
  - `ptr` = (owner+1) mod 5.
  - The search reruns in the same edge using the new `ptr`, and the block grants back-to-back if any `req` bit is set. Otherwise it goes to IDLE with `gnt=0`.
  - If the old owner is the only requester, it is re-granted with `beats` = 0.
- `ready` low stalls the grant: `beats` holds and there is no preemption, whatever other requests are pending.
- Requests from non-owners are ignored until a release.

## Timing
- Reset values: `state`=IDLE, `gnt`=0, `sel`=0, `owner`=0, `ptr`=0, `beats`=0, `valid`=0, `last`=0. `out` = `in0` because `sel`=0.
- Reset asserted mid-grant clears all state immediately, without waiting for a clock edge. After reset the search restarts at source 0.
- Grant latency: `req` sampled at edge N gives `gnt`, `sel` and `valid` during cycle N+1. First beat earliest at edge N+1.
- Back-to-back grants: no idle cycle. The new `sel` is valid during the cycle after the releasing edge.
- Throughput: 1 beat/cycle while `ready`=1. Maximum occupancy is `MAX_BEATS` beats per grant.
- `out` is combinational from registered `sel`. `valid` and `last` are combinational from `req` and registered state. There is no combinational path from `ready` to `valid`.

## Structure
- Shared package `mux_sched_pkg`: `NUM_SRC`=5, `SEL_W`=3, state encoding (IDLE=0, GRANT=1).
- One sub-module instance: `mux5_1 #(.SZE(SZE))`, with `sel` → `sel` and `out` → `out`. Its `outbar` output is left unconnected.
- The round-robin search is a pure function in the package, with args `req`, `ptr` and returns `{found, idx}`.

## Test plan
- Reset: with `rst_n`=0 and `req`=5'b11111, all outputs hold their reset values and `out`=`in0`. Release reset → `gnt`=00001 and `sel`=0 one cycle later.
- Burst limit: `req`=00100 held, `ready`=1, `MAX_BEATS`=4.
  - 4 beats of `in2`, with `last` on the 4th.
  - Then the grant is re-taken with `beats`=0, and `gnt` stays 00100 with no gap.
- Round-robin fairness: `req`=10011 held, `ready`=1 → grant order 0,1,4,0,… with 4 beats each. No idle cycles between grants.
- Stall: while granted to source 3, drop `ready` for 5 cycles.
  - `beats` holds, and `valid`=1 with `out`=`in3` throughout.
  - Raising `req[1]` does not preempt.
- Early drop: the owner deasserts `req` after 2 beats.
  - `valid` falls in the same cycle.
  - At the next edge the grant moves to the next requester, or to IDLE with `gnt`=0.
- Async reset mid-grant: pulse `rst_n` low between edges → `gnt`=0 and `valid`=0 immediately. After release, arbitration starts from source 0.
